// File: rtl/pim_microprog_sequencer.sv
// -----------------------------------------------------------------------------
// pim_microprog_sequencer
//
// Pops WORDS-word microprogram entries from the CPU-side FIFO and issues them
// one command at a time, word 0 first, to the PIM core command port. Before it
// issues the next command it waits for core_done. When no entry is in flight
// it also forwards direct CPU commands into the same port. A direct command
// wins over an entry when both are pending in IDLE.
//
// Optional feature (macro PIM_SEQ_WATCHDOG_EN):
//   defined   - a per-command watchdog aborts an entry or a direct command
//               after WDOG_CYCLES cycles without core_done and sets
//               err_timeout.
//   undefined - no counter, err_timeout tied low, waits are unbounded.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mp_valid/ready    FIFO entry present / pop strobe (one cycle per entry)
//   mp_data           WORDS packed command words, word 0 in LSBs
//   run_en            level gate for popping the next entry
//   cpu_cmd_*         direct CPU command valid/data/ready
//   core_cmd_*        command to the core, valid/ready handshake
//   core_done         one-cycle completion pulse from the core
//   seq_busy          FSM not in IDLE
//   idle              IDLE and nothing pending on either input
//   entries_done      completed-entry counter, wraps
//   err_illegal       sticky: an illegal opcode was skipped
//   err_timeout       sticky: watchdog expired
// -----------------------------------------------------------------------------
module pim_microprog_sequencer #(
    parameter int CMD_W       = 64,
    parameter int WORDS       = 4,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mp_valid,
    input  logic [CMD_W*WORDS-1:0] mp_data,
    output logic                   mp_ready,
    input  logic                   run_en,
    input  logic                   cpu_cmd_valid,
    input  logic [CMD_W-1:0]       cpu_cmd_data,
    output logic                   cpu_cmd_ready,
    output logic                   core_cmd_valid,
    output logic [CMD_W-1:0]       core_cmd_data,
    input  logic                   core_cmd_ready,
    input  logic                   core_done,
    output logic                   seq_busy,
    output logic                   idle,
    output logic [CNT_W-1:0]       entries_done,
    output logic                   err_illegal,
    output logic                   err_timeout
);

    // Legal opcodes. These must match the core's opcode map.
    localparam logic [7:0] OPC_FETCH_INPUT   = 8'h01;
    localparam logic [7:0] OPC_FETCH_WEIGHTS = 8'h02;
    localparam logic [7:0] OPC_COMPUTE       = 8'h03;
    localparam logic [7:0] OPC_STORE_OUTPUT  = 8'h04;

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_ADVANCE,
        S_D_ISSUE,
        S_D_WAIT
    } state_e;

    state_e                   state_q, state_d;
    logic [CMD_W*WORDS-1:0]   entry_q, entry_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CMD_W-1:0]         dcmd_q, dcmd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_illegal_q, err_illegal_d;

`ifdef PIM_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0]          wdog_q, wdog_d;
    logic                     err_timeout_q, err_timeout_d;
`endif

    logic [CMD_W-1:0]         words [WORDS];
    logic [CMD_W-1:0]         cur_word;
    logic [7:0]               cur_opc;
    logic                     cur_legal;
    logic                     mp_ready_c;
    logic                     cpu_ready_c;

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            words[i] = entry_q[i*CMD_W +: CMD_W];
        end
    end

    assign cur_word  = words[idx_q];
    assign cur_opc   = cur_word[CMD_W-1 -: 8];
    assign cur_legal = (cur_opc == OPC_FETCH_INPUT)   || (cur_opc == OPC_FETCH_WEIGHTS) ||
                       (cur_opc == OPC_COMPUTE)       || (cur_opc == OPC_STORE_OUTPUT);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d        = state_q;
        entry_d        = entry_q;
        idx_d          = idx_q;
        dcmd_d         = dcmd_q;
        cnt_d          = cnt_q;
        err_illegal_d  = err_illegal_q;
        mp_ready_c     = 1'b0;
        cpu_ready_c    = 1'b0;
        core_cmd_valid = 1'b0;
        core_cmd_data  = '0;
`ifdef PIM_SEQ_WATCHDOG_EN
        wdog_d         = wdog_q;
        err_timeout_d  = err_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cpu_cmd_valid) begin
                    cpu_ready_c = 1'b1;
                    dcmd_d      = cpu_cmd_data;
                    state_d     = S_D_ISSUE;
                end else if (mp_valid && run_en) begin
                    mp_ready_c = 1'b1;
                    entry_d    = mp_data;
                    idx_d      = '0;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                core_cmd_data = cur_word;
                if (cur_legal) begin
                    core_cmd_valid = 1'b1;
                    if (core_cmd_ready) begin
                        state_d = S_WAIT_DONE;
`ifdef PIM_SEQ_WATCHDOG_EN
                        wdog_d  = '0;
`endif
                    end
                end else begin
                    // An illegal word is skipped. The rest of the entry still runs.
                    err_illegal_d = 1'b1;
                    state_d       = S_ADVANCE;
                end
            end

            S_WAIT_DONE: begin
                if (core_done) begin
                    state_d = S_ADVANCE;
                end
`ifdef PIM_SEQ_WATCHDOG_EN
                else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end

            S_ADVANCE: begin
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end

            S_D_ISSUE: begin
                core_cmd_valid = 1'b1;
                core_cmd_data  = dcmd_q;
                if (core_cmd_ready) begin
                    state_d = S_D_WAIT;
`ifdef PIM_SEQ_WATCHDOG_EN
                    wdog_d  = '0;
`endif
                end
            end

            S_D_WAIT: begin
                if (core_done) begin
                    state_d = S_IDLE;
                end
`ifdef PIM_SEQ_WATCHDOG_EN
                else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the entry register is reset on purpose: a cleared entry leaves no stale command visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            entry_q       <= '0;
            idx_q         <= '0;
            dcmd_q        <= '0;
            cnt_q         <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            idx_q         <= idx_d;
            dcmd_q        <= dcmd_d;
            cnt_q         <= cnt_d;
            err_illegal_q <= err_illegal_d;
        end
    end

`ifdef PIM_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    // The input-dependent strobes are masked by rst_n. While reset is held,
    // this keeps the FIFO from seeing a pop and keeps every output at 0.
    assign mp_ready      = rst_n & mp_ready_c;
    assign cpu_cmd_ready = rst_n & cpu_ready_c;
    assign seq_busy      = (state_q != S_IDLE);
    assign idle          = rst_n & (state_q == S_IDLE) & ~mp_valid & ~cpu_cmd_valid;
    assign entries_done  = cnt_q;
    assign err_illegal   = err_illegal_q;

endmodule

// File: tb/tb_pim_microprog_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for pim_microprog_sequencer.
// A FIFO model and a CPU-command model feed the DUT. A core model accepts
// commands and pulses core_done a fixed latency after each one. Each expected
// core command is queued when its stimulus is created. The queue is popped
// and compared on every core handshake. Inputs change at posedge+#1. Outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pim_microprog_sequencer;

    localparam int CMD_W    = 64;
    localparam int WORDS    = 4;
    localparam int CNT_W    = 3;    // small, so the counter wrap shows up in a short run
    localparam int WDOG     = 16;
    localparam int DONE_LAT = 5;

    localparam logic [7:0] OPC_FI = 8'h01;
    localparam logic [7:0] OPC_FW = 8'h02;
    localparam logic [7:0] OPC_CO = 8'h03;
    localparam logic [7:0] OPC_ST = 8'h04;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   mp_valid = 1'b0;
    logic [CMD_W*WORDS-1:0] mp_data = '0;
    logic                   mp_ready;
    logic                   run_en = 1'b1;
    logic                   cpu_cmd_valid = 1'b0;
    logic [CMD_W-1:0]       cpu_cmd_data = '0;
    logic                   cpu_cmd_ready;
    logic                   core_cmd_valid;
    logic [CMD_W-1:0]       core_cmd_data;
    logic                   core_cmd_ready = 1'b1;
    logic                   core_done = 1'b0;
    logic                   seq_busy;
    logic                   idle;
    logic [CNT_W-1:0]       entries_done;
    logic                   err_illegal;
    logic                   err_timeout;

    pim_microprog_sequencer #(
        .CMD_W(CMD_W), .WORDS(WORDS), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mp_valid(mp_valid), .mp_data(mp_data), .mp_ready(mp_ready),
        .run_en(run_en),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_data(cpu_cmd_data), .cpu_cmd_ready(cpu_cmd_ready),
        .core_cmd_valid(core_cmd_valid), .core_cmd_data(core_cmd_data), .core_cmd_ready(core_cmd_ready),
        .core_done(core_done),
        .seq_busy(seq_busy), .idle(idle), .entries_done(entries_done),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CMD_W*WORDS-1:0] fifo_q [$];
    logic [CMD_W-1:0]       cpu_q  [$];
    logic [CMD_W-1:0]       exp_q  [$];

    bit pop_flag = 0, cpu_flag = 0, hs_flag = 0;
    bit withhold_done = 0;
    int done_cnt = 0;
    int stall = 0;
    int pops = 0;
    int cpu_acc = 0;
    int exp_entries = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk(input logic [7:0] opc, input logic [31:0] addr,
                                            input logic [15:0] mac);
        return {opc, 8'h00, addr, mac};
    endfunction

    function automatic bit is_legal(input logic [CMD_W-1:0] w);
        logic [7:0] o;
        o = w[63:56];
        return (o == OPC_FI) || (o == OPC_FW) || (o == OPC_CO) || (o == OPC_ST);
    endfunction

    task automatic push_entry(input logic [CMD_W-1:0] w0, input logic [CMD_W-1:0] w1,
                              input logic [CMD_W-1:0] w2, input logic [CMD_W-1:0] w3);
        logic [CMD_W-1:0] w [WORDS];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        fifo_q.push_back({w3, w2, w1, w0});
        for (int i = 0; i < WORDS; i++) begin
            if (is_legal(w[i])) exp_q.push_back(w[i]);
        end
        exp_entries++;
    endtask

    task automatic push_std();
        push_entry(mk(OPC_FI, 32'h1000, 16'd0), mk(OPC_FW, 32'h2000, 16'd0),
                   mk(OPC_CO, 32'h0, 16'd10000), mk(OPC_ST, 32'h3000, 16'd0));
    endtask

    task automatic push_direct(input logic [CMD_W-1:0] c);
        cpu_q.push_back(c);
        exp_q.push_back(c);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && fifo_q.size() == 0 && cpu_q.size() == 0 && idle)
                   && n < budget);
        if (n >= budget) check("wait_idle_bound", 64'd0, 64'd1);
    endtask

    task automatic wait_exp_size(input int sz, input int budget);
        int n = 0;
        while (exp_q.size() > sz && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("wait_exp_bound", 64'd0, 64'd1);
    endtask

    task automatic check_entries(input string tag);
        check(tag, 64'(entries_done), 64'(exp_entries % (1 << CNT_W)));
    endtask

    // Environment: FIFO, CPU source and core responder, all updated just after posedge.
    initial begin
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0 && !withhold_done) core_done = 1'b1;
            end
            if (hs_flag) begin hs_flag = 0; done_cnt = DONE_LAT; end
            if (pop_flag) begin pop_flag = 0; if (fifo_q.size() > 0) fifo_q.delete(0); end
            if (cpu_flag) begin cpu_flag = 0; if (cpu_q.size() > 0) cpu_q.delete(0); end
            mp_valid      = (fifo_q.size() > 0);
            mp_data       = mp_valid ? fifo_q[0] : '0;
            cpu_cmd_valid = (cpu_q.size() > 0);
            cpu_cmd_data  = cpu_cmd_valid ? cpu_q[0] : '0;
            if (stall > 0) begin core_cmd_ready = 1'b0; stall--; end
            else core_cmd_ready = 1'b1;
        end
    end

    // Scoreboard: compare every core handshake against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_cmd_valid && core_cmd_ready) begin
                hs_flag = 1;
                if (exp_q.size() == 0) check("unexpected_cmd", core_cmd_data, 64'd0);
                else check("cmd_order", core_cmd_data, exp_q.pop_front());
            end
            if (mp_valid && mp_ready) begin pop_flag = 1; pops++; end
            if (cpu_cmd_valid && cpu_cmd_ready) begin cpu_flag = 1; cpu_acc++; end
        end
    end

    initial begin
        int n;
        int pops0;
        logic [CMD_W-1:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mp_ready", 64'(mp_ready), 64'd0);
        check("rst_core_valid", 64'(core_cmd_valid), 64'd0);
        check("rst_core_data", core_cmd_data, 64'd0);
        check("rst_busy", 64'(seq_busy), 64'd0);
        check("rst_idle", 64'(idle), 64'd0);
        check("rst_entries", 64'(entries_done), 64'd0);
        check("rst_err", 64'({err_illegal, err_timeout}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 64'(idle), 64'd1);

        // Single entry, four commands in order
        pops0 = pops;
        push_std();
        wait_idle(200);
        check("t1_pops", 64'(pops - pops0), 64'd1);
        check_entries("t1_entries");
        check("t1_busy", 64'(seq_busy), 64'd0);

        // Three back-to-back entries
        pops0 = pops;
        for (int i = 0; i < 3; i++) begin
            push_entry(mk(OPC_FI, 32'h100 + i, 16'd1), mk(OPC_FW, 32'h200 + i, 16'd2),
                       mk(OPC_CO, 32'h300 + i, 16'(i + 7)), mk(OPC_ST, 32'h400 + i, 16'd3));
        end
        wait_idle(500);
        check("t2_pops", 64'(pops - pops0), 64'd3);
        check_entries("t2_entries");
        check("t2_idle", 64'(idle), 64'd1);

        // Core stalls for 7 cycles in ISSUE, and the first valid comes one cycle after the pop
        stall = 8;
        push_std();
        n = 0;
        do begin @(negedge clk); n++; end while (!core_cmd_valid && n < 20);
        check("t3_latency", 64'(n), 64'd2);
        held = core_cmd_data;
        n = 0;
        while (core_cmd_valid && !core_cmd_ready && n < 20) begin
            check("t3_stable", core_cmd_data, held);
            n++;
            @(negedge clk);
        end
        check("t3_stall_cycles", 64'(n), 64'd7);
        wait_idle(200);
        check_entries("t3_entries");

        // Illegal opcode in word 1 is skipped
        check("t4_err_before", 64'(err_illegal), 64'd0);
        push_entry(mk(OPC_FI, 32'h1111, 16'd4), mk(8'hFF, 32'h2222, 16'd5),
                   mk(OPC_CO, 32'h3333, 16'd6), mk(OPC_ST, 32'h4444, 16'd7));
        wait_idle(200);
        check("t4_err_illegal", 64'(err_illegal), 64'd1);
        check_entries("t4_entries");

        // Direct command beats an entry pending in the same cycle
        cpu_acc = 0;
        push_direct(mk(OPC_CO, 32'h0, 16'd5000));
        push_std();
        wait_idle(300);
        check("t5_cpu_ready_cycles", 64'(cpu_acc), 64'd1);
        check_entries("t5_entries");

        // A direct command that arrives mid-entry waits for the entry to finish (counter wraps here)
        push_std();
        wait_exp_size(2, 100);
        push_direct(mk(OPC_CO, 32'hABCD, 16'd77));
        wait_idle(300);
        check("t6_cpu_acc", 64'(cpu_acc), 64'd2);
        check_entries("t6_entries_wrap");

        // Dropping run_en mid-entry lets that entry finish but blocks the next pop
        pops0 = pops;
        push_std();
        wait_exp_size(3, 100);
        run_en = 1'b0;
        push_std();
        repeat (60) @(negedge clk);
        check("t7_pops_gated", 64'(pops - pops0), 64'd1);
        check("t7_entries_gated", 64'(entries_done), 64'((exp_entries - 1) % (1 << CNT_W)));
        run_en = 1'b1;
        wait_idle(300);
        check_entries("t7_entries");

        // Reset in WAIT_DONE: outputs go to 0 at once and nothing is popped
        pops0 = pops;
        push_std();
        push_std();
        wait_exp_size(7, 100);
        @(negedge clk);
        check("t8_busy_before", 64'(seq_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t8_busy", 64'(seq_busy), 64'd0);
        check("t8_valid", 64'(core_cmd_valid), 64'd0);
        check("t8_err", 64'(err_illegal), 64'd0);
        check("t8_entries", 64'(entries_done), 64'd0);
        repeat (3) @(negedge clk);
        check("t8_mp_ready", 64'(mp_ready), 64'd0);
        check("t8_no_pop", 64'(pops - pops0), 64'd1);
        fifo_q.delete();
        exp_q.delete();
        done_cnt = 0; hs_flag = 0; pop_flag = 0;
        exp_entries = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t8_idle_after", 64'(idle), 64'd1);

`ifdef PIM_SEQ_WATCHDOG_EN
        // Watchdog: the core never signals done
        withhold_done = 1;
        push_std();
        exp_entries--;  // this entry is abandoned
        n = 0;
        while (!err_timeout && n < 100) begin @(negedge clk); n++; end
        check("t9_err_timeout", 64'(err_timeout), 64'd1);
        check("t9_timeout_window", 64'(n >= WDOG && n <= WDOG + 8), 64'd1);
        check("t9_busy", 64'(seq_busy), 64'd0);
        check_entries("t9_entries");
        exp_q.delete();
        withhold_done = 0;
`else
        check("t9_err_timeout_tied", 64'(err_timeout), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
